// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch/decode decoupling buffer.
package fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_packet_t;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PARTIAL = 2'd1,
    BUF_FULL    = 2'd2
  } fetch_buf_state_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// Packet storage: synchronous write, asynchronous read so the head is show-ahead.
module fetch_buffer_ram
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          We,
  input  logic [AW-1:0] Waddr,
  input  fetch_packet_t Wdata,
  input  logic [AW-1:0] Raddr,
  output fetch_packet_t Rdata
);

  fetch_packet_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (We) mem[Waddr] <= Wdata;
  end

  assign Rdata = mem[Raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode FIFO replacing the IF/ID register; Buf_Ready stalls the PC when full.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Flush,
  input  logic             F_Valid,
  input  logic [31:0]      Instr_F,
  input  logic [31:0]      PC_F,
  input  logic [31:0]      PC_Plus_4_F,
  output logic             Buf_Ready,
  input  logic             D_Ready,
  output logic             D_Valid,
  output logic [31:0]      Instr_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC_Plus_4_D,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt, cnt_nxt;
  fetch_buf_state_t state, state_nxt;
  fetch_packet_t    wr_pkt, head_pkt;
  logic             push, pop;

  // A transfer happens on an edge where valid and ready are both high; Flush
  // overrides both sides. Ready/valid come only from registered state, so
  // there is no combinational path from D_Ready to Buf_Ready.
  assign Buf_Ready = (state != BUF_FULL);
  assign D_Valid   = (state != BUF_EMPTY);
  assign push      = F_Valid && Buf_Ready && !Flush;
  assign pop       = D_Valid && D_Ready && !Flush;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CNT_ONE;
    else if (pop && !push) cnt_nxt = cnt - CNT_ONE;
  end

  always_comb begin
    state_nxt = BUF_PARTIAL;
    if (cnt_nxt == '0)          state_nxt = BUF_EMPTY;
    else if (cnt_nxt == DEPTH_C) state_nxt = BUF_FULL;
  end

  always_ff @(posedge CLK) begin
    if (RST || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      state  <= BUF_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  assign wr_pkt = '{instr: Instr_F, pc: PC_F, pc_plus_4: PC_Plus_4_F};

  fetch_buffer_ram #(.DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .CLK   (CLK),
    .We    (push && !RST),
    .Waddr (wr_ptr),
    .Wdata (wr_pkt),
    .Raddr (rd_ptr),
    .Rdata (head_pkt)
  );

  // Empty buffer presents a NOP so decode never sees stale storage.
  assign Instr_D     = D_Valid ? head_pkt.instr     : NOP_INSTR;
  assign PC_D        = D_Valid ? head_pkt.pc        : 32'd0;
  assign PC_Plus_4_D = D_Valid ? head_pkt.pc_plus_4 : 32'd0;
  assign Count       = cnt;

`ifndef SYNTHESIS
  a_cnt_bound:    assert property (@(posedge CLK) disable iff (RST) cnt <= DEPTH_C);
  a_no_push_full: assert property (@(posedge CLK) disable iff (RST) !(push && cnt == DEPTH_C));
  a_no_pop_empty: assert property (@(posedge CLK) disable iff (RST) !(pop && cnt == '0));
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            Flush = 1'b0;
  logic            F_Valid = 1'b1;
  logic [31:0]     Instr_F = '0;
  logic [31:0]     PC_F = '0;
  logic [31:0]     PC_Plus_4_F = 32'd4;
  logic            Buf_Ready;
  logic            D_Ready = 1'b0;
  logic            D_Valid;
  logic [31:0]     Instr_D, PC_D, PC_Plus_4_D;
  logic [PTR_W:0]  Count;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush), .F_Valid(F_Valid), .Instr_F(Instr_F),
    .PC_F(PC_F), .PC_Plus_4_F(PC_Plus_4_F), .Buf_Ready(Buf_Ready), .D_Ready(D_Ready),
    .D_Valid(D_Valid), .Instr_D(Instr_D), .PC_D(PC_D), .PC_Plus_4_D(PC_Plus_4_D),
    .Count(Count)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // reference model: occupancy and packet contents in push order
  int          mcnt = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (RST || Flush) begin
      mcnt = 0;
      exp_q.delete();
      if (RST) mon_en = 1'b1;
    end else begin
      bit acc, rel;
      acc = F_Valid && (mcnt < DEPTH);
      rel = D_Ready && (mcnt > 0);
      if (acc) exp_q.push_back({Instr_F, PC_F, PC_Plus_4_F});
      mcnt = mcnt + int'(acc) - int'(rel);
    end
  end

  // monitor: occupancy flags every cycle, head packet popped on handshake
  always @(negedge CLK) begin
    if (mon_en) begin
      logic [95:0] e;
      check("count", 32'(Count), 32'(mcnt));
      check("d_valid", 32'(D_Valid), 32'(mcnt > 0));
      check("buf_ready", 32'(Buf_Ready), 32'(mcnt < DEPTH));
      if (mcnt == 0) begin
        check("empty_instr", Instr_D, NOP);
        check("empty_pc", PC_D, 32'd0);
        check("empty_pc4", PC_Plus_4_D, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'(mcnt));
      end else begin
        if (D_Ready && !Flush && !RST) e = exp_q.pop_front();
        else e = exp_q[0];
        check("head_instr", Instr_D, e[95:64]);
        check("head_pc", PC_D, e[63:32]);
        check("head_pc4", PC_Plus_4_D, e[31:0]);
      end
    end
  end

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive(input bit fv, input logic [31:0] pc, input bit dr, input bit fl, input bit rst);
    F_Valid     = fv;
    PC_F        = pc;
    PC_Plus_4_F = pc + 32'd4;
    Instr_F     = $urandom;
    D_Ready     = dr;
    Flush       = fl;
    RST         = rst;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    #1;
    // reset with fetch asserting valid
    drive(1, 32'h0, 0, 0, 1);
    drive(1, 32'h0, 0, 0, 1);
    @(negedge CLK);
    check("rst_instr", Instr_D, NOP);
    check("rst_count", 32'(Count), 32'd0);
    @(posedge CLK); #1;
    // fill, then an ignored 5th packet
    for (int i = 0; i < 5; i++) drive(1, 32'(i * 4), 0, 0, 0);
    @(negedge CLK);
    check("full_head_pc", PC_D, 32'h0);
    check("full_ready", 32'(Buf_Ready), 32'd0);
    @(posedge CLK); #1;
    // drain in order
    for (int i = 0; i < 5; i++) drive(0, 32'h0, 1, 0, 0);
    // two in, then ten simultaneous push/pop cycles wrapping the pointers
    drive(1, 32'h100, 0, 0, 0);
    drive(1, 32'h104, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 32'h108 + 32'(i * 4), 1, 0, 0);
    @(negedge CLK);
    check("steady_count", 32'(Count), 32'd2);
    check("steady_head", PC_D, 32'h128);
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 0, 0);
    // flush with concurrent push and pop
    for (int i = 0; i < 3; i++) drive(1, 32'h200 + 32'(i * 4), 0, 0, 0);
    drive(1, 32'h300, 1, 1, 0);
    drive(1, 32'h40, 0, 0, 0);
    @(negedge CLK);
    check("post_flush_pc", PC_D, 32'h40);
    check("post_flush_count", 32'(Count), 32'd1);
    @(posedge CLK); #1;
    drive(0, 32'h0, 1, 0, 0);
    // reset while full
    for (int i = 0; i < 4; i++) drive(1, 32'h500 + 32'(i * 4), 0, 0, 0);
    drive(1, 32'h600, 0, 0, 1);
    @(negedge CLK);
    check("mid_rst_ready", 32'(Buf_Ready), 32'd1);
    check("mid_rst_valid", 32'(D_Valid), 32'd0);
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 0, 0);
    // random traffic with occasional flush and reset
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      bit fv, dr, fl, rs;
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 59) == 0);
      drive(fv, pc, dr, fl, rs);
      pc = pc + 32'd4;
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 32'h0, 1, 0, 0);
    @(negedge CLK);
    check("final_empty", 32'(Count), 32'd0);
    check("final_sb", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
